// File: rtl/ahb_slave_port_arbiter.sv
// Three-master arbiter for one shared AHB output port. It keeps bursts and locked sequences intact.
// Default build is round-robin with a hold limit; define ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module ahb_slave_port_arbiter #(
   parameter int HOLD_LIMIT = 4
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic [2:0] REQ,
   input  logic [2:0] SEQ,
   input  logic [2:0] LOCK,
   input  logic       HREADYM,
   output logic [1:0] ADDR_SEL,
   output logic       ADDR_VALID,
   output logic [2:0] HGRANT,
   output logic [1:0] DATA_SEL,
   output logic       DATA_VALID,
   output logic       ARB_LOCKED
);

   typedef enum logic [1:0] {NONE, OWN, LOCKED} state_t;

   state_t     r_state, w_nstate;
   logic [1:0] r_owner, w_nowner, w_winner;
   logic [1:0] r_dsel;
   logic       r_dvalid;
   logic       w_eval_own;

   function automatic logic [1:0] mod3_add(input logic [1:0] v, input logic [1:0] k);
      logic [2:0] s;
      s = {1'b0, v} + {1'b0, k};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

`ifdef ARB_FIXED_PRIORITY_EN
   always_comb begin
      w_winner = 2'd2;
      if (REQ[0])      w_winner = 2'd0;
      else if (REQ[1]) w_winner = 2'd1;
   end
`else
   logic [3:0] r_hold;
   logic [4:0] w_cnt;
   logic [1:0] w_o1, w_o2;
   logic       w_inc;

   // w_cnt includes the beat being accepted on this edge, so HOLD_LIMIT counts grants.
   assign w_inc = ADDR_VALID & REQ[r_owner] & ~SEQ[r_owner];
   assign w_cnt = {1'b0, r_hold} + {4'b0, w_inc};
   assign w_o1  = mod3_add(r_owner, 2'd1);
   assign w_o2  = mod3_add(r_owner, 2'd2);

   always_comb begin
      w_winner = r_owner;
      if (REQ[r_owner] && (w_cnt < 5'(HOLD_LIMIT))) w_winner = r_owner;
      else if (REQ[w_o1])                           w_winner = w_o1;
      else if (REQ[w_o2])                           w_winner = w_o2;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET)
         r_hold <= 4'd0;
      else if (HREADYM) begin
         if ((w_nowner != r_owner) || (w_nstate == NONE)) r_hold <= 4'd0;
         else if (w_inc && (r_hold != 4'hf))             r_hold <= r_hold + 4'd1;
      end
   end
`endif

   always_comb begin
      w_nstate   = r_state;
      w_nowner   = r_owner;
      w_eval_own = 1'b0;
      case (r_state)
         NONE: begin
            if (|REQ) begin
               w_nowner = w_winner;
               w_nstate = LOCK[w_winner] ? LOCKED : OWN;
            end
         end
         LOCKED:  w_eval_own = ~LOCK[r_owner];
         default: w_eval_own = 1'b1;
      endcase
      // A released lock is re-arbitrated on the same edge, exactly like OWN.
      if (w_eval_own) begin
         if (REQ[r_owner] & (SEQ[r_owner] | LOCK[r_owner]))
            w_nstate = LOCK[r_owner] ? LOCKED : OWN;
         else if (~|REQ)
            w_nstate = NONE;
         else begin
            w_nowner = w_winner;
            w_nstate = LOCK[w_winner] ? LOCKED : OWN;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state  <= NONE;
         r_owner  <= 2'd0;
         r_dsel   <= 2'd0;
         r_dvalid <= 1'b0;
      end else if (HREADYM) begin
         r_state  <= w_nstate;
         r_owner  <= w_nowner;
         r_dsel   <= r_owner;
         r_dvalid <= ADDR_VALID & REQ[r_owner];
      end
   end

   assign ADDR_SEL   = r_owner;
   assign ADDR_VALID = (r_state != NONE);
   assign HGRANT     = ADDR_VALID ? (3'b001 << r_owner) : 3'b000;
   assign DATA_SEL   = r_dsel;
   assign DATA_VALID = r_dvalid;
   assign ARB_LOCKED = (r_state == LOCKED);

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Directed bench for ahb_slave_port_arbiter (HOLD_LIMIT=1); expectations are queued at drive time and checked after the edge.
module tb_ahb_slave_port_arbiter;

   logic       HCLK, HRESET, HREADYM;
   logic [2:0] REQ, SEQ, LOCK;
   logic [1:0] ADDR_SEL, DATA_SEL;
   logic       ADDR_VALID, DATA_VALID, ARB_LOCKED;
   logic [2:0] HGRANT;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] sel;
      logic       valid;
      logic [2:0] grant;
      logic [1:0] dsel;
      logic       dvalid;
      logic       locked;
      string      tag;
   } exp_t;

   exp_t sb[$];

   logic [1:0] p_sel, p_dsel;
   logic       p_valid, p_dvalid;

   ahb_slave_port_arbiter #(.HOLD_LIMIT(1)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .REQ(REQ), .SEQ(SEQ), .LOCK(LOCK),
      .HREADYM(HREADYM), .ADDR_SEL(ADDR_SEL), .ADDR_VALID(ADDR_VALID),
      .HGRANT(HGRANT), .DATA_SEL(DATA_SEL), .DATA_VALID(DATA_VALID),
      .ARB_LOCKED(ARB_LOCKED)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string t, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic rdy, input logic [2:0] req,
                       input logic [2:0] seq, input logic [2:0] lock,
                       input logic [1:0] xsel, input logic xv, input logic xl,
                       input string tag);
      exp_t e, o;
      HRESET = rst; HREADYM = rdy; REQ = req; SEQ = seq; LOCK = lock;
      e.sel = xsel; e.valid = xv; e.locked = xl; e.tag = tag;
      e.grant = xv ? (3'b001 << xsel) : 3'b000;
      if (rst) begin
         e.dsel = 2'd0; e.dvalid = 1'b0;
      end else if (rdy) begin
         e.dsel = p_sel; e.dvalid = p_valid & req[p_sel];
      end else begin
         e.dsel = p_dsel; e.dvalid = p_dvalid;
      end
      p_sel = e.sel; p_valid = e.valid; p_dsel = e.dsel; p_dvalid = e.dvalid;
      sb.push_back(e);
      @(posedge HCLK);
      #1;
      o = sb.pop_front();
      chk({o.tag, ".addr_sel"},   {1'b0, ADDR_SEL},   {1'b0, o.sel});
      chk({o.tag, ".addr_valid"}, {2'b0, ADDR_VALID}, {2'b0, o.valid});
      chk({o.tag, ".hgrant"},     HGRANT,             o.grant);
      chk({o.tag, ".data_sel"},   {1'b0, DATA_SEL},   {1'b0, o.dsel});
      chk({o.tag, ".data_valid"}, {2'b0, DATA_VALID}, {2'b0, o.dvalid});
      chk({o.tag, ".arb_locked"}, {2'b0, ARB_LOCKED}, {2'b0, o.locked});
   endtask

   initial begin
      p_sel = 2'd0; p_dsel = 2'd0; p_valid = 1'b0; p_dvalid = 1'b0;
      HRESET = 1'b1; HREADYM = 1'b1; REQ = 3'b111; SEQ = 3'b000; LOCK = 3'b000;
      //   rst rdy req     seq     lock    sel  v  l
      step(1, 1, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0, "rst0");
      step(1, 1, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0, "rst1");
`ifdef ARB_FIXED_PRIORITY_EN
      step(0, 1, 3'b110, 3'b000, 3'b000, 2'd1, 1, 0, "fp_first");
      step(0, 1, 3'b111, 3'b010, 3'b000, 2'd1, 1, 0, "fp_seq_hold");
      step(0, 1, 3'b111, 3'b000, 3'b000, 2'd0, 1, 0, "fp_to_low");
      step(0, 1, 3'b111, 3'b000, 3'b000, 2'd0, 1, 0, "fp_stay_low");
`else
      step(0, 1, 3'b111, 3'b000, 3'b000, 2'd0, 1, 0, "rel");
      step(0, 1, 3'b111, 3'b000, 3'b000, 2'd1, 1, 0, "rot1");
      step(0, 1, 3'b111, 3'b000, 3'b000, 2'd2, 1, 0, "rot2");
      step(0, 1, 3'b111, 3'b000, 3'b000, 2'd0, 1, 0, "rot0");
      step(0, 1, 3'b111, 3'b000, 3'b000, 2'd1, 1, 0, "rot1b");
      step(0, 1, 3'b111, 3'b010, 3'b000, 2'd1, 1, 0, "burst1");
      step(0, 1, 3'b111, 3'b010, 3'b000, 2'd1, 1, 0, "burst2");
      step(0, 1, 3'b111, 3'b010, 3'b000, 2'd1, 1, 0, "burst3");
      step(0, 1, 3'b111, 3'b000, 3'b000, 2'd2, 1, 0, "burst_end");
      step(0, 1, 3'b111, 3'b000, 3'b100, 2'd2, 1, 1, "lock_in");
      step(0, 1, 3'b011, 3'b000, 3'b100, 2'd2, 1, 1, "lock_hold1");
      step(0, 1, 3'b011, 3'b000, 3'b100, 2'd2, 1, 1, "lock_hold2");
      step(0, 1, 3'b011, 3'b000, 3'b000, 2'd0, 1, 0, "lock_rel");
      step(0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 1, 0, "wait1");
      step(0, 0, 3'b101, 3'b000, 3'b000, 2'd0, 1, 0, "wait2");
      step(0, 0, 3'b010, 3'b000, 3'b000, 2'd0, 1, 0, "wait3");
      step(0, 0, 3'b111, 3'b000, 3'b110, 2'd0, 1, 0, "wait4");
      step(0, 0, 3'b001, 3'b000, 3'b000, 2'd0, 1, 0, "wait5");
      step(0, 1, 3'b010, 3'b000, 3'b000, 2'd1, 1, 0, "post_wait");
      step(0, 1, 3'b000, 3'b000, 3'b000, 2'd1, 0, 0, "idle_park");
      step(0, 1, 3'b100, 3'b000, 3'b000, 2'd2, 1, 0, "from_none");
      step(0, 1, 3'b100, 3'b000, 3'b000, 2'd2, 1, 0, "lone_keep1");
      step(0, 1, 3'b100, 3'b000, 3'b000, 2'd2, 1, 0, "lone_keep2");
      step(0, 1, 3'b100, 3'b000, 3'b100, 2'd2, 1, 1, "lock_again");
      step(1, 0, 3'b111, 3'b000, 3'b100, 2'd0, 0, 0, "rst_midlock");
      step(0, 1, 3'b111, 3'b000, 3'b000, 2'd0, 1, 0, "post_rst");
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_slave_port_arbiter.md
AHB_SLAVE_PORT_ARBITER -- requirements
Module: ahb_slave_port_arbiter

Interface
REQ-001 Parameter: HOLD_LIMIT, default 4, max consecutive NONSEQ grants to one port while another port requests (legal 1..15).
REQ-002 Port: HCLK  input  1  AHB system clock; all state updates on rising edge.
REQ-003 Port: HRESET  input  1  reset, synchronous and active-high.
REQ-004 Port: REQ  input  3  bit i = input port i presents a valid transfer (HSEL & HTRANS[1]) to this output port.
REQ-005 Port: SEQ  input  3  bit i = port i's current transfer is SEQ (burst continuation).
REQ-006 Port: LOCK  input  3  bit i = port i asserts HMASTLOCK.
REQ-007 Port: HREADYM  input  1  HREADY of the shared output port; arbitration state advances only when 1.
REQ-008 Port: ADDR_SEL  output  2  address-phase owner index 0..2; parks on last owner when idle.
REQ-009 Port: ADDR_VALID  output  1  owner currently holds grant.
REQ-010 Port: HGRANT  output  3  one-hot of ADDR_SEL when ADDR_VALID=1, else 3'b000.
REQ-011 Port: DATA_SEL  output  2  data-phase port index.
REQ-012 Port: DATA_VALID  output  1  data phase in progress for DATA_SEL.
REQ-013 Port: ARB_LOCKED  output  1  1 in LOCKED state.

Function
REQ-014 States SHALL be NONE, OWN, LOCKED; ADDR_VALID=1 in OWN and LOCKED only; ARB_LOCKED=1 in LOCKED only.
REQ-015 With HREADYM=0 all registers (state, ADDR_SEL, DATA_SEL, DATA_VALID, hold counter) SHALL hold.
REQ-016 With HREADYM=1: DATA_SEL <= ADDR_SEL and DATA_VALID <= ADDR_VALID & REQ[ADDR_SEL] (one-cycle address-to-data latency).
REQ-017 NONE: REQ=0 -> stay; else select winner, -> LOCKED if LOCK[winner], else OWN.
REQ-018 LOCKED: LOCK[owner]=1 -> stay with owner regardless of REQ[owner]; LOCK[owner]=0 -> evaluate as OWN the same edge.
REQ-019 OWN: REQ[owner]&SEQ[owner] -> keep owner (burst never split); REQ[owner]&LOCK[owner] -> LOCKED, same owner.
REQ-020 OWN, otherwise: REQ=0 -> NONE, ADDR_SEL parks unchanged; else select winner per REQ-021.
REQ-021 Round-robin winner: if REQ[owner] and hold count < HOLD_LIMIT keep owner; else first requester scanning owner+1, owner+2, owner (mod 3).
REQ-022 Hold counter (4 bits) SHALL increment on each HREADYM=1 edge with ADDR_VALID & REQ[owner] & ~SEQ[owner], saturate at 15, clear to 0 on owner change or entry to NONE.
REQ-023 Hold counter SHALL be ignored (owner kept) when no other port requests.
REQ-024 Owner change SHALL occur only on an edge with HREADYM=1; ADDR_SEL never takes value 3.

Reset
REQ-025 HRESET=1 at an edge SHALL force, independent of HREADYM: state NONE, ADDR_SEL=0, ADDR_VALID=0, HGRANT=0, DATA_SEL=0, DATA_VALID=0, ARB_LOCKED=0, counter 0.
REQ-026 Reset mid-burst or mid-lock SHALL abandon the owner; first post-reset arbitration follows REQ-017.

Configuration
REQ-027 Macro ARB_FIXED_PRIORITY_EN defined: winner = lowest-index requester at every arbitration point; HOLD_LIMIT and counter unused; SEQ/LOCK holds unchanged.
REQ-028 Macro undefined: round-robin with hold limit per REQ-021/022.

Verification
REQ-029 Reset: HRESET=1 two cycles, REQ=3'b111 -> all outputs 0; release -> next edge ADDR_SEL=0, HGRANT=3'b001.
REQ-030 Rotation, HOLD_LIMIT=1: REQ=3'b111, SEQ=0, HREADYM=1 -> ADDR_SEL 0,1,2,0 on successive edges; DATA_SEL trails by one cycle.
REQ-031 Burst hold: owner 1, SEQ[1]=1 for 3 beats, REQ=3'b111 -> ADDR_SEL=1 for all 3 beats, then 2.
REQ-032 Lock: owner 2, LOCK[2]=1, REQ=3'b011 -> ADDR_SEL=2, ARB_LOCKED=1 until LOCK[2]=0, then ADDR_SEL=0.
REQ-033 Wait states: HREADYM=0 for 5 cycles with REQ changing -> ADDR_SEL, DATA_SEL, DATA_VALID unchanged.
REQ-034 Fixed priority (ARB_FIXED_PRIORITY_EN): REQ=3'b110 then 3'b111 -> ADDR_SEL=1, then 0 at next NONSEQ boundary.
